// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: round-robin frame scheduler sharing one bit-serial pattern detector between two requesters
// Optional PSC_LOAD_TIMEOUT_EN adds res_abort and aborts a frame after 15 stalled LOAD cycles.
module pattern_scan_ctrl #(
  parameter int WORD_W      = 8,
  parameter int FRAME_WORDS = 4,
  parameter int CNT_W       = 8,
  parameter int DET_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [WORD_W-1:0] req_data0,
  input  logic [WORD_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic              det_rst,
  output logic              det_d,
  output logic              det_valid,
  input  logic              det_pattern,
  output logic              res_valid,
  output logic              res_src,
  output logic [CNT_W-1:0]  res_count
`ifdef PSC_LOAD_TIMEOUT_EN
  ,
  output logic              res_abort
`endif
);
  localparam int BW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  localparam int FW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
  localparam int DW = DET_LAT > 0 ? $clog2(DET_LAT + 1) : 1;
  typedef enum logic [2:0] {IDLE, CLR, LOAD, SHIFT, DRAIN, REPORT} state_t;
  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [FW-1:0]     word_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [CNT_W-1:0]  count;
  logic              pat_q, grant, last_grant;
`ifdef PSC_LOAD_TIMEOUT_EN
  logic [3:0]        stall;
`endif
  logic              gsel, acc, in_win;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WORD_W-1:0] wsel;
  logic [1:0]        gmask;
  always_comb begin
    gsel    = &req_valid ? ~last_grant : req_valid[1];
    acc     = req_valid[grant] & req_ready[grant];
    wsel    = grant ? req_data1 : req_data0;
    gmask   = grant ? 2'b10 : 2'b01;
    in_win  = state == LOAD || state == SHIFT || state == DRAIN;
    cnt_nxt = (in_win && det_pattern && !pat_q && count != '1) ? count + 1'b1 : count;
  end
  assign det_d = shreg[WORD_W-1];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      drain_cnt  <= '0;
      count      <= '0;
      pat_q      <= 1'b0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      req_ready  <= 2'b00;
      det_rst    <= 1'b0;
      det_valid  <= 1'b0;
      res_valid  <= 1'b0;
      res_src    <= 1'b0;
      res_count  <= '0;
`ifdef PSC_LOAD_TIMEOUT_EN
      stall      <= 4'd0;
      res_abort  <= 1'b0;
`endif
    end else begin
      det_rst   <= 1'b0;
      res_valid <= 1'b0;
      count     <= cnt_nxt;
      pat_q     <= det_pattern;
      case (state)
        IDLE: if (|req_valid) begin
          grant   <= gsel;
          det_rst <= 1'b1;
          state   <= CLR;
        end
        CLR: begin
          count     <= '0;
          pat_q     <= 1'b0;
          word_cnt  <= '0;
          req_ready <= gmask;
          state     <= LOAD;
`ifdef PSC_LOAD_TIMEOUT_EN
          stall     <= 4'd0;
`endif
        end
        LOAD: begin
          if (acc) begin
            shreg     <= wsel;
            bit_cnt   <= BW'(WORD_W - 1);
            req_ready <= 2'b00;
            det_valid <= 1'b1;
            state     <= SHIFT;
`ifdef PSC_LOAD_TIMEOUT_EN
            stall     <= 4'd0;
          end else if (stall == 4'd14) begin
            req_ready <= 2'b00;
            res_valid <= 1'b1;
            res_src   <= grant;
            res_count <= cnt_nxt;
            res_abort <= 1'b1;
            state     <= REPORT;
          end else begin
            stall     <= stall + 4'd1;
`endif
          end
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            det_valid <= 1'b0;
            if (word_cnt == FW'(FRAME_WORDS - 1)) begin
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              word_cnt  <= word_cnt + 1'b1;
              req_ready <= gmask;
              state     <= LOAD;
            end
          end
        end
        DRAIN: begin
          // cnt_nxt folds in an edge arriving on the final drain cycle
          if (drain_cnt == DW'(DET_LAT - 1)) begin
            res_valid <= 1'b1;
            res_src   <= grant;
            res_count <= cnt_nxt;
`ifdef PSC_LOAD_TIMEOUT_EN
            res_abort <= 1'b0;
`endif
            state     <= REPORT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        REPORT: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
